data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Parametrised successor to the MEM-stage data memory of the MIPS pipeline.
- Byte-addressable, big-endian RAM with byte, halfword and word accesses, and sign/zero extension on loads.
- Configurable depth and wait states; an FSM drives a pipeline stall signal while an access is pending.
- Misaligned and out-of-range accesses raise error flags instead of silently wrapping.

Parameters:
- ADDR_BITS, 10, byte address width; depth = 2**ADDR_BITS bytes.
- WAIT_STATES, 0, extra access cycles (0..15); 0 gives single-cycle memory.
- INIT_PATTERN, 1, at time 0: if 1, word at byte address 4k holds 4k+4 and all other bytes are 0; if 0, all bytes are 0.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request; has priority over mem_read if both are high.
- mem_addr  in  32  byte address (EXE/MEM ALU result).
- mem_wdata  in  32  store data, right-justified.
- mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
- mem_rdata  out  32  extended load result.
- mem_done  out  1  one-cycle pulse when an access (or its error) completes.
- mem_stall  out  1  freeze IF..MEM pipeline registers.
- mem_misalign  out  1  error pulse, coincident with mem_done.
- mem_oob  out  1  error pulse, coincident with mem_done.

Behaviour:
- States: IDLE, WAIT. A 4-bit down-counter cnt runs in WAIT.
- Request = mem_read | mem_write, sampled only in IDLE. Address, data, size, op and extension are latched at that edge (cycle T).
- Error checks, evaluated in IDLE:
  - misalign: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - oob: addr[31:ADDR_BITS]!=0.
  - Misalign wins if both apply.
  - On error: no RAM update; mem_rdata <= 0; done and flag pulse at T+1; state stays IDLE; no stall regardless of WAIT_STATES.
- WAIT_STATES=0: access performed at the end of T; done at T+1; mem_stall never asserted. Back-to-back requests every cycle are legal.
- WAIT_STATES=W>0:
  - IDLE: cnt <= W-1, go to WAIT.
  - WAIT with cnt!=0: decrement cnt.
  - WAIT with cnt==0: perform the access, go to IDLE.
  - Done at T+W+1.
  - mem_stall = (IDLE & request & no error) | (WAIT & cnt!=0). It is combinational and high for exactly cycles T..T+W-1.
  - Requests seen while in WAIT are ignored; they are the same held instruction.
- Store layout, big-endian, A = latched address:
  - byte: mem[A] = wdata[7:0].
  - half: mem[A] = wdata[15:8], mem[A+1] = wdata[7:0].
  - word: mem[A..A+3] = wdata[31:24], [23:16], [15:8], [7:0].
- Loads: mem_rdata is registered at the access edge.
  - byte is extended from mem[A].
  - half is {mem[A], mem[A+1]} extended.
  - word is the 4 bytes, MSB first.
- Store completion: done pulses; mem_rdata is unchanged.
- mem_rdata holds its value until the next completed load or error.
- Reset:
  - state IDLE, cnt 0, mem_rdata 0, mem_done/mem_misalign/mem_oob 0; mem_stall low.
  - A pending write in WAIT is discarded, never partially written.
  - RAM contents are not affected by reset.
- Read-after-write: a load issued the cycle after a store's done sees the stored data.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - function load_extend(bytes, size, unsigned).
- Sub-module byte_ram: 2**ADDR_BITS x 8 storage, 4 byte-lane write enables, 4-byte read at A..A+3 (wrapping index), INIT_PATTERN initialisation. The FSM, checks and lane steering stay in data_memory_ctrl.

Test Plan:
- W=0, INIT_PATTERN=1: word load from 0x1C -> rdata 0x00000020, done at T+1, stall never high.
- sw 0x8899AABB @0x40; lb @0x40 -> 0xFFFFFF88; lbu @0x43 -> 0x000000BB; lh @0x42 -> 0xFFFFAABB; lhu @0x40 -> 0x00008899.
- sh 0x1234 @0x41 -> misalign pulse with done at T+1, RAM unchanged (lw @0x40 still 0x8899AABB); lw @0x400 with ADDR_BITS=10 -> oob pulse, rdata 0.
- W=3: lw @0x0 at T -> stall high T..T+2, done at T+4 with rdata 0x00000004; a repeated request during WAIT produces no second done.
- W=3: sw 0xDEADBEEF @0x10, rst high at T+2 -> IDLE, stall low next cycle; later lw @0x10 -> 0x00000014 (write discarded).
- W=0: mem_read and mem_write both high, sw 0x55 @0x20 -> store performed, rdata unchanged; following lw @0x20 -> 0x00000055.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
package mem_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LANES   = 4;

  // Access size encodings as presented on mem_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  // Controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Request attributes held while an access waits out its extra cycles.
  typedef struct packed {
    logic              is_write;
    logic              is_unsigned;
    mem_size_e         size;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Extends the MSB-first byte group read at A into a 32-bit load result.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] bytes,
                                                    input logic [1:0]        size,
                                                    input logic              is_unsigned);
    logic [DATA_W-1:0] res;
    case (size)
      SZ_BYTE: res = is_unsigned ? {24'h000000, bytes[31:24]}
                                 : {{24{bytes[31]}}, bytes[31:24]};
      SZ_HALF: res = is_unsigned ? {16'h0000, bytes[31:16]}
                                 : {{16{bytes[31]}}, bytes[31:16]};
      default: res = bytes;
    endcase
    return res;
  endfunction

  // Power-up image: the word at byte address 4k holds 4k+4, stored big-endian.
  function automatic logic [7:0] init_byte(input logic [31:0] addr);
    logic [31:0] word;
    logic [7:0]  res;
    word = {addr[31:2], 2'b00} + 32'd4;
    case (addr[1:0])
      2'd0:    res = word[31:24];
      2'd1:    res = word[23:16];
      2'd2:    res = word[15:8];
      default: res = word[7:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide RAM with a 4-byte window starting at addr_i (wrapping) and
// per-lane write enables; lane 0 (we_i[3], data[31:24]) is the byte at addr_i.
module byte_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned INIT_PATTERN = 1
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_c_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  // Cells hold (contents XOR power-up image), so a cleared array reads back
  // as the image and no load sequence is needed at time 0.
  logic [7:0]           store_q   [DEPTH];
  logic [ADDR_BITS-1:0] lane_addr [LANES];
  logic [7:0]           img       [LANES];
  logic [7:0]           wbyte     [LANES];

  function automatic logic [7:0] image(input logic [ADDR_BITS-1:0] a);
    return (INIT_PATTERN != 0) ? init_byte(32'(a)) : 8'h00;
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_addr[g] = addr_i + ADDR_BITS'(g);
    assign img[g]       = image(lane_addr[g]);
    assign wbyte[g]     = wdata_i[31-8*g -: 8] ^ img[g];
    assign rdata_c_o[31-8*g -: 8] = store_q[lane_addr[g]] ^ img[g];
  end

  // Byte-lane writes; storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we_i[LANES-1-i]) begin
        store_q[lane_addr[i]] <= wbyte[i];
      end
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: big-endian byte/half/word access with optional wait
// states, pipeline stall, and misalign / out-of-range error pulses.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 10,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned INIT_PATTERN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_oob
);

  localparam bit HAS_WAIT = (WAIT_STATES != 0);

  mem_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  mem_req_t             req_q;
  logic [ADDR_BITS-1:0] addr_q;

  logic                 req_c;
  logic                 mis_c;
  logic                 oob_c;
  logic                 err_c;
  logic                 fire_c;
  mem_req_t             cur_c;
  mem_req_t             acc_c;
  logic [ADDR_BITS-1:0] acc_addr_c;
  logic [LANES-1:0]     we_c;
  logic [DATA_W-1:0]    lane_wdata_c;
  logic [DATA_W-1:0]    ram_rdata_c;

  // Request decode and alignment / range checks on the live inputs.
  always_comb begin
    req_c = mem_read | mem_write;
    case (mem_size)
      SZ_HALF: mis_c = mem_addr[0];
      SZ_WORD: mis_c = (mem_addr[1:0] != 2'b00);
      SZ_RSVD: mis_c = 1'b1;
      default: mis_c = 1'b0;
    endcase
    oob_c = ((mem_addr >> ADDR_BITS) != 32'd0);
    err_c = mis_c | oob_c;
    cur_c.is_write    = mem_write;
    cur_c.is_unsigned = mem_unsigned;
    cur_c.size        = mem_size_e'(mem_size);
    cur_c.wdata       = mem_wdata;
  end

  // Pick the live request (single-cycle path) or the latched one (after WAIT).
  always_comb begin
    acc_c      = (state_q == ST_IDLE) ? cur_c : req_q;
    acc_addr_c = (state_q == ST_IDLE) ? mem_addr[ADDR_BITS-1:0] : addr_q;
    fire_c     = ~rst & (((state_q == ST_IDLE) & req_c & ~err_c & ~HAS_WAIT) |
                         ((state_q == ST_WAIT) & (cnt_q == '0)));
  end

  // Steer store data into MSB-first lanes and raise the matching enables.
  always_comb begin
    we_c         = '0;
    lane_wdata_c = acc_c.wdata;
    case (acc_c.size)
      SZ_BYTE: begin
        we_c         = 4'b1000;
        lane_wdata_c = {acc_c.wdata[7:0], 24'h000000};
      end
      SZ_HALF: begin
        we_c         = 4'b1100;
        lane_wdata_c = {acc_c.wdata[15:0], 16'h0000};
      end
      SZ_WORD: we_c = 4'b1111;
      default: we_c = 4'b0000;
    endcase
    if (!(fire_c & acc_c.is_write)) begin
      we_c = '0;
    end
  end

  // Stall covers the request cycle and every WAIT cycle but the last.
  always_comb begin
    mem_stall = ~rst & (((state_q == ST_IDLE) & req_c & ~err_c & HAS_WAIT) |
                        ((state_q == ST_WAIT) & (cnt_q != '0)));
  end

  byte_ram #(
    .ADDR_BITS   (ADDR_BITS),
    .INIT_PATTERN(INIT_PATTERN)
  ) u_ram (
    .clk      (clk),
    .we_i     (we_c),
    .addr_i   (acc_addr_c),
    .wdata_i  (lane_wdata_c),
    .rdata_c_o(ram_rdata_c)
  );

  // Controller FSM with registered load data and completion/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      addr_q       <= '0;
      mem_rdata    <= '0;
      mem_done     <= 1'b0;
      mem_misalign <= 1'b0;
      mem_oob      <= 1'b0;
    end else begin
      mem_done     <= 1'b0;
      mem_misalign <= 1'b0;
      mem_oob      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_c) begin
            if (err_c) begin
              mem_done     <= 1'b1;
              mem_misalign <= mis_c;
              mem_oob      <= ~mis_c & oob_c;
              mem_rdata    <= '0;
            end else if (HAS_WAIT) begin
              req_q   <= cur_c;
              addr_q  <= mem_addr[ADDR_BITS-1:0];
              cnt_q   <= CNT_W'(WAIT_STATES - 1);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (fire_c) begin
        mem_done <= 1'b1;
        if (!acc_c.is_write) begin
          mem_rdata <= load_extend(ram_rdata_c, acc_c.size, acc_c.is_unsigned);
        end
      end
    end
  end

endmodule
